// File: rtl/bias_buf_pkg.sv
// Shared types and sizing helpers for the double-buffered bias store.
package bias_buf_pkg;

    typedef enum logic {LOAD, FULL} bias_bank_state_t;

    // Entries per bank.
    function automatic int unsigned entry_count(input int unsigned num_ch,
                                                input int unsigned depth);
        return num_ch * depth;
    endfunction

    // Pointer / entry-count width: must represent a full bank count, not just the last index.
    function automatic int unsigned ptr_width(input int unsigned num_ch,
                                              input int unsigned depth);
        return $clog2(num_ch * depth + 1);
    endfunction

endpackage

// File: rtl/bias_bank_mem.sv
// One bias bank: entry-wide write port, group-wide combinational read, and its fill count.
module bias_bank_mem #(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned GRP_W  = 4,
    parameter int unsigned CNT_W  = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [IN_W-1:0]          wdata,
    input  logic                     cnt_we,
    input  logic [CNT_W-1:0]         cnt_wdata,
    input  logic [GRP_W-1:0]         rgrp,
    output logic [NUM_CH*IN_W-1:0]   rdata,
    output logic [CNT_W-1:0]         n_entries
);

    logic [IN_W-1:0] mem [NUM_CH*DEPTH];
    logic [CNT_W-1:0] n_entries_q;

    // Storage is deliberately not reset; n_entries masks stale contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_entries_q <= '0;
        end else if (cnt_we) begin
            n_entries_q <= cnt_wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rdata[c*IN_W +: IN_W] = mem[ADDR_W'(32'(rgrp) * NUM_CH + 32'(c))];
        end
    end

    assign n_entries = n_entries_q;

endmodule

// File: rtl/bias_pingpong_buf.sv
// Ping-pong bias store: shadow bank fills from the DMA stream while the PE array reads the active one.
module bias_pingpong_buf
    import bias_buf_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_valid,
    input  logic [IN_W-1:0]           ld_data,
    input  logic                      ld_last,
    output logic                      ld_ready,
    input  logic                      swap,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_grp,
    output logic [NUM_CH*OUT_W-1:0]   bias_out,
    output logic                      bias_valid,
    output logic                      bank_ready,
    output logic                      active_bank,
    output logic                      swap_err
);

    localparam int unsigned Entries = entry_count(NUM_CH, DEPTH);
    localparam int unsigned PtrW    = ptr_width(NUM_CH, DEPTH);
    localparam int unsigned AddrW   = $clog2(Entries);
    localparam int unsigned GrpW    = $clog2(DEPTH);

    bias_bank_state_t state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic active_q, active_d;
    logic swap_err_q, swap_err_d;
    logic [NUM_CH*OUT_W-1:0] bias_q, bias_d;
    logic bias_valid_q;

    logic accept, last_hit, swap_ok;
    logic [NUM_CH*IN_W-1:0] rdata [2];
    logic [PtrW-1:0] n_ent [2];

    assign accept   = ld_valid && (state_q == LOAD);
    assign last_hit = accept && (ld_last || (ptr_q == PtrW'(Entries - 1)));
    assign swap_ok  = swap && (state_q == FULL);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_shadow;
        assign is_shadow = (active_q != 1'(b));

        // Count is latched on fill completion, and cleared when this bank becomes the shadow.
        bias_bank_mem #(
            .IN_W   (IN_W),
            .NUM_CH (NUM_CH),
            .DEPTH  (DEPTH),
            .ADDR_W (AddrW),
            .GRP_W  (GrpW),
            .CNT_W  (PtrW)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .we        (accept && is_shadow),
            .waddr     (ptr_q[AddrW-1:0]),
            .wdata     (ld_data),
            .cnt_we    ((last_hit && is_shadow) || (swap_ok && !is_shadow)),
            .cnt_wdata (last_hit ? ptr_q + PtrW'(1) : '0),
            .rgrp      (rd_grp),
            .rdata     (rdata[b]),
            .n_entries (n_ent[b])
        );
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        active_d   = active_q;
        swap_err_d = 1'b0;
        unique case (state_q)
            LOAD: begin
                swap_err_d = swap;
                if (accept) begin
                    ptr_d = ptr_q + PtrW'(1);
                    if (last_hit) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (swap) begin
                    state_d  = LOAD;
                    ptr_d    = '0;
                    active_d = ~active_q;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        bias_d = bias_q;
        if (rd_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (32'(rd_grp) * NUM_CH + 32'(c) < 32'(n_ent[active_q])) begin
                    bias_d[c*OUT_W +: OUT_W] = OUT_W'($signed(rdata[active_q][c*IN_W +: IN_W]));
                end else begin
                    bias_d[c*OUT_W +: OUT_W] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            ptr_q        <= '0;
            active_q     <= 1'b0;
            swap_err_q   <= 1'b0;
            bias_q       <= '0;
            bias_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            active_q     <= active_d;
            swap_err_q   <= swap_err_d;
            bias_q       <= bias_d;
            bias_valid_q <= rd_en;
        end
    end

    assign ld_ready    = (state_q == LOAD);
    assign bank_ready  = (state_q == FULL);
    assign active_bank = active_q;
    assign swap_err    = swap_err_q;
    assign bias_out    = bias_q;
    assign bias_valid  = bias_valid_q;

endmodule

// File: tb/tb_bias_pingpong_buf.sv
// Scoreboard bench for bias_pingpong_buf: driver pushes model expectations, monitor compares.
module tb_bias_pingpong_buf;

    localparam int IN_W = 8;
    localparam int OUT_W = 16;
    localparam int NUM_CH = 4;
    localparam int DEPTH = 16;
    localparam int TOTAL = NUM_CH * DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ld_valid = 1'b0;
    logic [IN_W-1:0] ld_data = '0;
    logic ld_last = 1'b0;
    logic ld_ready;
    logic swap = 1'b0;
    logic rd_en = 1'b0;
    logic [3:0] rd_grp = '0;
    logic [NUM_CH*OUT_W-1:0] bias_out;
    logic bias_valid, bank_ready, active_bank, swap_err;

    always #5 clk = ~clk;

    bias_pingpong_buf #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .swap        (swap),
        .rd_en       (rd_en),
        .rd_grp      (rd_grp),
        .bias_out    (bias_out),
        .bias_valid  (bias_valid),
        .bank_ready  (bank_ready),
        .active_bank (active_bank),
        .swap_err    (swap_err)
    );

    typedef struct packed {
        logic [NUM_CH*OUT_W-1:0] bias;
        logic valid;
        logic ldr;
        logic bkr;
        logic act;
        logic serr;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: two banks of signed ints, fill counts, and a full/not-full flag.
    int m_bank [2][TOTAL];
    int m_n [2];
    int m_active;
    int m_ptr;
    bit m_full;
    logic [NUM_CH*OUT_W-1:0] m_bias;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t snapshot(input bit valid, input bit serr);
        exp_t e;
        e.bias = m_bias;
        e.valid = valid;
        e.ldr = !m_full;
        e.bkr = m_full;
        e.act = m_active[0];
        e.serr = serr;
        return e;
    endfunction

    task automatic model_reset();
        m_n[0] = 0;
        m_n[1] = 0;
        m_active = 0;
        m_ptr = 0;
        m_full = 0;
        m_bias = '0;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            {ld_valid, ld_last, swap, rd_en} = '0;
            model_reset();
            exp_q.push_back(snapshot(1'b0, 1'b0));
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit s,
                        input bit r, input logic [3:0] g);
        bit serr;
        @(negedge clk);
        rst_n = 1'b1;
        ld_valid = v;
        ld_data = d;
        ld_last = l;
        swap = s;
        rd_en = r;
        rd_grp = g;
        if (r) begin
            for (int c = 0; c < NUM_CH; c++) begin
                int idx;
                idx = int'(g) * NUM_CH + c;
                m_bias[c*OUT_W +: OUT_W] = (idx < m_n[m_active]) ? 16'(m_bank[m_active][idx]) : 16'h0;
            end
        end
        serr = s && !m_full;
        if (!m_full) begin
            if (v) begin
                m_bank[1-m_active][m_ptr] = int'($signed(d));
                m_ptr++;
                if (l || m_ptr == TOTAL) begin
                    m_n[1-m_active] = m_ptr;
                    m_full = 1;
                end
            end
        end else if (s) begin
            m_active = 1 - m_active;
            m_full = 0;
            m_ptr = 0;
            m_n[1-m_active] = 0;
        end
        exp_q.push_back(snapshot(r, serr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 4'h0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bias_out", 64'(bias_out), 64'(e.bias));
            chk("bias_valid", 64'(bias_valid), 64'(e.valid));
            chk("ld_ready", 64'(ld_ready), 64'(e.ldr));
            chk("bank_ready", 64'(bank_ready), 64'(e.bkr));
            chk("active_bank", 64'(active_bank), 64'(e.act));
            chk("swap_err", 64'(swap_err), 64'(e.serr));
        end
    end

    initial begin
        model_reset();
        do_reset(2);

        // Read of the empty bank after reset.
        step(0, 8'h00, 0, 0, 1, 4'h0);
        idle(1);
        chk("reset_read", 64'(bias_out), 64'h0);

        // Early swap, then partial load with swap colliding with the ld_last beat.
        step(0, 8'h00, 0, 1, 0, 4'h0);
        for (int k = 1; k <= 6; k++) step(1, 8'(k), k == 6, k == 6, 0, 4'h0);
        idle(1);
        step(0, 8'h00, 0, 1, 0, 4'h0);
        step(0, 8'h00, 0, 0, 1, 4'h1);
        step(0, 8'h00, 0, 0, 1, 4'h3);
        chk("partial_grp1", 64'(bias_out), 64'h0000_0000_0006_0005);
        idle(1);

        // Full-depth load with no ld_last, then backpressure with ld_valid held high.
        for (int k = 0; k < TOTAL; k++) step(1, 8'(k - 32), 0, 0, 0, 4'h0);
        for (int k = 0; k < 3; k++) step(1, 8'h7f, 0, 0, 0, 4'h0);
        step(0, 8'h00, 0, 1, 0, 4'h0);
        step(0, 8'h00, 0, 0, 1, 4'hf);
        idle(1);
        chk("full_grp15", 64'(bias_out), 64'h001F_001E_001D_001C);
        step(0, 8'h00, 0, 0, 1, 4'h0);
        idle(1);
        chk("full_grp0", 64'(bias_out), 64'hFFE3_FFE2_FFE1_FFE0);

        // Ping-pong: continuous reads while loading the shadow, swap with a read in the same cycle.
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 0; k < 10; k++) step(1, 8'($urandom), k == 9, 0, 1, 4'($urandom_range(0, 3)));
            step(0, 8'h00, 0, 1, 1, 4'h0);
            for (int k = 0; k < 3; k++) step(0, 8'h00, 0, 0, 1, 4'(k));
        end

        // Reset mid-load discards the partial fill.
        for (int k = 0; k < 3; k++) step(1, 8'(k + 40), 0, 0, 0, 4'h0);
        do_reset(2);
        step(0, 8'h00, 0, 0, 1, 4'h0);
        step(0, 8'h00, 0, 1, 1, 4'h1);
        idle(1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 11) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, 4'($urandom));
        end
        idle(2);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
